// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
//
// Purpose:
//   Shared definitions for blocks that sit in front of the SPI RAM controller:
//   request-sequencer FSM state encodings and the word-width derivation used
//   to size data buses from the controller's byte-oriented word size.
//
// Contents:
//   state_t            3-bit FSM state type
//   ST_*               FSM state constants
//   data_width_bits()  bytes-per-word -> bits-per-word
//   is_read_state()    true for the two states that own a read transaction
// -----------------------------------------------------------------------------
package spi_ram_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RD_ISSUE = 3'd1;
    localparam state_t ST_RD_WAIT  = 3'd2;
    localparam state_t ST_WR_ISSUE = 3'd3;
    localparam state_t ST_WR_WAIT  = 3'd4;

    function automatic int data_width_bits(input int bytes);
        return bytes * 8;
    endfunction

    function automatic logic is_read_state(input state_t st);
        return (st == ST_RD_ISSUE) || (st == ST_RD_WAIT);
    endfunction

endpackage

// File: rtl/spi_ram_word_fifo.sv
// -----------------------------------------------------------------------------
// spi_ram_word_fifo
//
// Purpose:
//   Small synchronous word FIFO with a registered head. The head word is held
//   in its own register so the consumer sees a flop output rather than a
//   memory read mux. An empty FIFO presents zero on the head.
//
// Ports:
//   i_clk        clock
//   i_rstn       asynchronous active-low reset
//   i_push       write i_push_data at the tail (ignored when full or flushing)
//   i_push_data  word to write
//   i_pop        drop the head word (ignored when empty or flushing)
//   i_flush      discard all entries; wins over push and pop
//   o_count      number of stored words, 0..DEPTH
//   o_valid      FIFO non-empty
//   o_head       current head word (zero when empty)
// -----------------------------------------------------------------------------
module spi_ram_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_push  = i_push & ~i_flush & ~w_full;
    assign w_pop   = i_pop  & ~i_flush & ~w_empty;

    // Storage carries no reset; only pointers, count and head are control.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Head tracking: after a pop the next stored word (if any) moves
            // up; when popping the last word the simultaneous push (if any)
            // becomes the head. A push into an empty FIFO lands in the head.
            if (w_pop) begin
                if (r_count > CNT_W'(1)) begin
                    r_head <= r_mem[r_rd_ptr + PTR_W'(1)];
                end else if (w_push) begin
                    r_head <= i_push_data;
                end else begin
                    r_head <= '0;
                end
            end else if (w_push && w_empty) begin
                r_head <= i_push_data;
            end
        end
    end

    assign o_count = r_count;
    assign o_valid = ~w_empty;
    assign o_head  = r_head;

endmodule

// File: rtl/spi_ram_read_streamer.sv
// -----------------------------------------------------------------------------
// spi_ram_read_streamer
//
// Purpose:
//   Sole request sequencer in front of the SPI RAM controller. Streams
//   consecutive words from a base address into a small FIFO for a consumer
//   and interleaves single-word writes, which take priority over reads.
//   Converts the controller's start/busy protocol into valid/ready: a start
//   is held until busy is observed, and a result is taken when busy falls.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   stream_start                   pulse: load base/len, flush FIFO
//   stream_stop                    pulse: cancel remaining reads, flush FIFO
//   stream_base, stream_len        first byte address, word count
//   stream_active                  reads remain or a live read is in flight
//   rd_valid, rd_data, rd_ready    FIFO head handshake to the consumer
//   wr_valid, wr_ready             write request handshake
//   wr_addr, wr_data               write address and data
//   ctrl_addr, ctrl_data           request address/data to the controller
//   ctrl_start_read/_write         request strobes, held until busy seen
//   ctrl_data_out, ctrl_busy       controller read result and busy flag
// -----------------------------------------------------------------------------
module spi_ram_read_streamer
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int ADDR_BITS        = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rstn,

    input  logic                          stream_start,
    input  logic                          stream_stop,
    input  logic [ADDR_BITS-1:0]          stream_base,
    input  logic [ADDR_BITS-1:0]          stream_len,
    output logic                          stream_active,

    output logic                          rd_valid,
    output logic [DATA_WIDTH_BYTES*8-1:0] rd_data,
    input  logic                          rd_ready,

    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_BITS-1:0]          wr_addr,
    input  logic [DATA_WIDTH_BYTES*8-1:0] wr_data,

    output logic [ADDR_BITS-1:0]          ctrl_addr,
    output logic [DATA_WIDTH_BYTES*8-1:0] ctrl_data,
    output logic                          ctrl_start_read,
    output logic                          ctrl_start_write,
    input  logic [DATA_WIDTH_BYTES*8-1:0] ctrl_data_out,
    input  logic                          ctrl_busy
);

    localparam int DATA_WIDTH_BITS = data_width_bits(DATA_WIDTH_BYTES);
    localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_BITS-1:0] ADDR_STEP = ADDR_BITS'(DATA_WIDTH_BYTES);
    localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(FIFO_DEPTH);

    state_t                     r_state;
    logic [ADDR_BITS-1:0]       r_ctrl_addr;
    logic [DATA_WIDTH_BITS-1:0] r_ctrl_data;
    logic                       r_start_read;
    logic                       r_start_write;
    logic [ADDR_BITS-1:0]       r_next_addr;
    logic [ADDR_BITS-1:0]       r_remaining;
    logic                       r_discard;

    logic                       w_cancel;
    logic                       w_rd_state;
    logic                       w_rd_done;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_fifo_room;
    logic                       w_wr_go;
    logic                       w_rd_go;
    logic [CNT_W-1:0]           w_fifo_count;
    logic                       w_fifo_valid;
    logic [DATA_WIDTH_BITS-1:0] w_fifo_head;

    // Either stream control pulse invalidates the current stream contents.
    assign w_cancel   = stream_start | stream_stop;
    assign w_rd_state = is_read_state(r_state);
    assign w_rd_done  = (r_state == ST_RD_WAIT) & ~ctrl_busy;

    // A read that was cancelled (now or earlier) still finishes on the bus
    // but its word is dropped and it does not advance the stream.
    assign w_push = w_rd_done & ~r_discard & ~w_cancel;
    assign w_pop  = w_fifo_valid & rd_ready;

    assign w_fifo_room = (w_fifo_count < FULL_CNT);
    assign w_wr_go     = (r_state == ST_IDLE) & wr_valid;
    // No read is launched on a cancel cycle: the address/count are about to
    // be replaced and the FIFO is being flushed.
    assign w_rd_go     = (r_state == ST_IDLE) & ~wr_valid & ~w_cancel
                       & (r_remaining != '0) & w_fifo_room;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_ctrl_addr   <= '0;
            r_ctrl_data   <= '0;
            r_start_read  <= 1'b0;
            r_start_write <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_go) begin
                        r_ctrl_addr   <= wr_addr;
                        r_ctrl_data   <= wr_data;
                        r_start_write <= 1'b1;
                        r_state       <= ST_WR_ISSUE;
                    end else if (w_rd_go) begin
                        r_ctrl_addr  <= r_next_addr;
                        r_start_read <= 1'b1;
                        r_state      <= ST_RD_ISSUE;
                    end
                end
                // The controller samples start only every other cycle, so
                // the strobe stays up until busy proves it was taken.
                ST_RD_ISSUE: begin
                    if (ctrl_busy) begin
                        r_start_read <= 1'b0;
                        r_state      <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (!ctrl_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WR_ISSUE: begin
                    if (ctrl_busy) begin
                        r_start_write <= 1'b0;
                        r_state       <= ST_WR_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (!ctrl_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_start_read  <= 1'b0;
                    r_start_write <= 1'b0;
                end
            endcase
        end
    end

    // Stream position. stream_start has priority over stream_stop; a
    // completing read only advances the stream when its data is kept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_next_addr <= '0;
            r_remaining <= '0;
        end else if (stream_start) begin
            r_next_addr <= stream_base;
            r_remaining <= stream_len;
        end else if (stream_stop) begin
            r_remaining <= '0;
        end else if (w_push) begin
            r_next_addr <= r_next_addr + ADDR_STEP;
            r_remaining <= r_remaining - ADDR_BITS'(1);
        end
    end

    // Discard marks the in-flight read as stale; it clears when that read
    // finishes. A cancel on the completion cycle itself needs no flag since
    // w_push already looks at w_cancel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_discard <= 1'b0;
        end else if (w_rd_done) begin
            r_discard <= 1'b0;
        end else if (w_cancel && w_rd_state) begin
            r_discard <= 1'b1;
        end
    end

    spi_ram_word_fifo #(
        .WIDTH (DATA_WIDTH_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_push      (w_push),
        .i_push_data (ctrl_data_out),
        .i_pop       (w_pop),
        .i_flush     (w_cancel),
        .o_count     (w_fifo_count),
        .o_valid     (w_fifo_valid),
        .o_head      (w_fifo_head)
    );

    assign stream_active    = (r_remaining != '0) | (w_rd_state & ~r_discard);
    assign rd_valid         = w_fifo_valid;
    assign rd_data          = w_fifo_head;
    assign wr_ready         = (r_state == ST_IDLE);
    assign ctrl_addr        = r_ctrl_addr;
    assign ctrl_data        = r_ctrl_data;
    assign ctrl_start_read  = r_start_read;
    assign ctrl_start_write = r_start_write;

endmodule

// File: tb/tb_spi_ram_read_streamer.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_read_streamer
//
// Directed bench for spi_ram_read_streamer with a behavioural SPI RAM
// controller: memory byte at address A reads as A[7:0], start is sampled only
// on alternate cycles, busy stays high for four cycles per transaction.
// -----------------------------------------------------------------------------
module tb_spi_ram_read_streamer;

    logic        clk;
    logic        rstn;
    logic        stream_start;
    logic        stream_stop;
    logic [15:0] stream_base;
    logic [15:0] stream_len;
    logic        stream_active;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [15:0] ctrl_addr;
    logic [31:0] ctrl_data;
    logic        ctrl_start_read;
    logic        ctrl_start_write;
    logic [31:0] ctrl_data_out;
    logic        ctrl_busy;

    int n_tests = 0;
    int n_fail  = 0;

    spi_ram_read_streamer #(
        .DATA_WIDTH_BYTES (4),
        .ADDR_BITS        (16),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .stream_start     (stream_start),
        .stream_stop      (stream_stop),
        .stream_base      (stream_base),
        .stream_len       (stream_len),
        .stream_active    (stream_active),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .rd_ready         (rd_ready),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .ctrl_addr        (ctrl_addr),
        .ctrl_data        (ctrl_data),
        .ctrl_start_read  (ctrl_start_read),
        .ctrl_start_write (ctrl_start_write),
        .ctrl_data_out    (ctrl_data_out),
        .ctrl_busy        (ctrl_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural controller ----------------
    logic        m_phase;
    logic [2:0]  m_cnt;
    logic        m_is_rd;
    logic [15:0] m_addr;
    int          n_rd_issued = 0;
    int          n_rd_done   = 0;
    logic        op_kind [$];
    logic [15:0] op_addr [$];
    logic [31:0] op_data [$];

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase       <= 1'b0;
            m_cnt         <= 3'd0;
            m_is_rd       <= 1'b0;
            m_addr        <= 16'd0;
            ctrl_busy     <= 1'b0;
            ctrl_data_out <= 32'd0;
        end else begin
            m_phase <= ~m_phase;
            if (!ctrl_busy) begin
                if (m_phase && (ctrl_start_read || ctrl_start_write)) begin
                    ctrl_busy <= 1'b1;
                    m_cnt     <= 3'd3;
                    m_is_rd   <= ctrl_start_read;
                    m_addr    <= ctrl_addr;
                    op_kind.push_back(ctrl_start_write);
                    op_addr.push_back(ctrl_addr);
                    op_data.push_back(ctrl_data);
                    if (ctrl_start_read) n_rd_issued <= n_rd_issued + 1;
                end
            end else if (m_cnt == 3'd0) begin
                ctrl_busy <= 1'b0;
                if (m_is_rd) begin
                    ctrl_data_out <= mem_word(m_addr);
                    n_rd_done     <= n_rd_done + 1;
                end
            end else begin
                m_cnt <= m_cnt - 3'd1;
            end
        end
    end

    // ---------------- monitors ----------------
    logic [31:0] q_pop [$];
    int          hs_cnt  = 0;
    int          viol    = 0;
    int          run_len = 0;
    int          min_len = 100;
    int          max_len = 0;
    logic        last_s  = 1'b0;
    logic        last_b  = 1'b0;
    wire         mon_s   = ctrl_start_read | ctrl_start_write;

    always @(posedge clk) begin
        if (rstn && rd_valid && rd_ready) q_pop.push_back(rd_data);
        if (rstn && wr_valid && wr_ready) hs_cnt <= hs_cnt + 1;
    end

    always @(posedge clk) begin
        if (!rstn) begin
            last_s  <= 1'b0;
            last_b  <= 1'b0;
            run_len <= 0;
        end else begin
            // A start that drops without busy having been seen while it was high.
            if (last_s && !last_b && !mon_s) viol <= viol + 1;
            last_s <= mon_s;
            last_b <= ctrl_busy;
            if (mon_s) begin
                run_len <= run_len + 1;
            end else if (run_len != 0) begin
                if (run_len < min_len) min_len <= run_len;
                if (run_len > max_len) max_len <= run_len;
                run_len <= 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [15:0] base, input logic [15:0] len);
        stream_base  = base;
        stream_len   = len;
        stream_start = 1'b1;
        @(negedge clk);
        stream_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((stream_active || ctrl_busy || ctrl_start_read || ctrl_start_write) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_in_time"}, 32'(n < 600), 32'd1);
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (!ctrl_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_seen"}, 32'(ctrl_busy), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int pb;
        int ob;
        int ib;
        int db;
        int hb;
        int n;
        logic [31:0] exp8 [8];

        rstn         = 1'b0;
        stream_start = 1'b0;
        stream_stop  = 1'b0;
        stream_base  = 16'd0;
        stream_len   = 16'd0;
        rd_ready     = 1'b0;
        wr_valid     = 1'b0;
        wr_addr      = 16'd0;
        wr_data      = 32'd0;
        tick(3);

        // Reset state
        chk("rst_rd_valid",      32'(rd_valid),         32'd0);
        chk("rst_rd_data",       rd_data,               32'd0);
        chk("rst_stream_active", 32'(stream_active),    32'd0);
        chk("rst_wr_ready",      32'(wr_ready),         32'd1);
        chk("rst_start_read",    32'(ctrl_start_read),  32'd0);
        chk("rst_start_write",   32'(ctrl_start_write), 32'd0);
        chk("rst_ctrl_addr",     32'(ctrl_addr),        32'd0);
        chk("rst_ctrl_data",     ctrl_data,             32'd0);

        rstn = 1'b1;
        tick(2);

        // Basic stream of three words
        rd_ready = 1'b1;
        pb = q_pop.size();
        ib = n_rd_issued;
        pulse_start(16'h0100, 16'd3);
        chk("s1_active_after_start", 32'(stream_active), 32'd1);
        wait_done("s1");
        tick(30);
        chk("s1_count",   32'(q_pop.size() - pb), 32'd3);
        chk("s1_word0",   q_pop[pb],              32'h00010203);
        chk("s1_word1",   q_pop[pb+1],            32'h04050607);
        chk("s1_word2",   q_pop[pb+2],            32'h08090A0B);
        chk("s1_reads",   32'(n_rd_issued - ib),  32'd3);
        chk("s1_active",  32'(stream_active),     32'd0);
        chk("s1_rd_valid", 32'(rd_valid),         32'd0);

        // Address wrap
        pb = q_pop.size();
        ob = op_addr.size();
        pulse_start(16'hFFFC, 16'd2);
        wait_done("s2");
        tick(5);
        chk("s2_count", 32'(q_pop.size() - pb), 32'd2);
        chk("s2_word0", q_pop[pb],              32'hFCFDFEFF);
        chk("s2_word1", q_pop[pb+1],            32'h00010203);
        chk("s2_addr0", 32'(op_addr[ob]),       32'h0000FFFC);
        chk("s2_addr1", 32'(op_addr[ob+1]),     32'h00000000);

        // Back-pressure: FIFO fills at four words, then drains in order
        rd_ready = 1'b0;
        pb = q_pop.size();
        ib = n_rd_issued;
        pulse_start(16'h0210, 16'd8);
        tick(100);
        chk("s3_reads_stalled", 32'(n_rd_issued - ib), 32'd4);
        chk("s3_rd_valid",      32'(rd_valid),         32'd1);
        chk("s3_head",          rd_data,               32'h10111213);
        chk("s3_active",        32'(stream_active),    32'd1);
        chk("s3_no_busy",       32'(ctrl_busy),        32'd0);
        rd_ready = 1'b1;
        wait_done("s3");
        tick(6);
        exp8[0] = 32'h10111213; exp8[1] = 32'h14151617;
        exp8[2] = 32'h18191A1B; exp8[3] = 32'h1C1D1E1F;
        exp8[4] = 32'h20212223; exp8[5] = 32'h24252627;
        exp8[6] = 32'h28292A2B; exp8[7] = 32'h2C2D2E2F;
        chk("s3_count", 32'(q_pop.size() - pb), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s3_word%0d", i), q_pop[pb+i], exp8[i]);
        end
        chk("s3_total_reads", 32'(n_rd_issued - ib), 32'd8);

        // Write interleaved while a read is in flight
        pb = q_pop.size();
        ob = op_kind.size();
        hb = hs_cnt;
        pulse_start(16'h0300, 16'd4);
        wait_busy("s4");
        wr_addr  = 16'h0040;
        wr_data  = 32'hDEADBEEF;
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("s4_wr_ready_seen", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        wait_done("s4");
        tick(6);
        chk("s4_handshakes", 32'(hs_cnt - hb),     32'd1);
        chk("s4_op0_kind",   32'(op_kind[ob]),     32'd0);
        chk("s4_op0_addr",   32'(op_addr[ob]),     32'h00000300);
        chk("s4_op1_kind",   32'(op_kind[ob+1]),   32'd1);
        chk("s4_op1_addr",   32'(op_addr[ob+1]),   32'h00000040);
        chk("s4_op1_data",   op_data[ob+1],        32'hDEADBEEF);
        chk("s4_op2_kind",   32'(op_kind[ob+2]),   32'd0);
        chk("s4_op2_addr",   32'(op_addr[ob+2]),   32'h00000304);
        chk("s4_count",      32'(q_pop.size() - pb), 32'd4);
        chk("s4_word0",      q_pop[pb],            32'h00010203);
        chk("s4_word3",      q_pop[pb+3],          32'h0C0D0E0F);

        // stream_stop while the first read waits on busy
        pb = q_pop.size();
        ib = n_rd_issued;
        db = n_rd_done;
        pulse_start(16'h0400, 16'd4);
        wait_busy("s5");
        @(negedge clk);
        stream_stop = 1'b1;
        @(negedge clk);
        stream_stop = 1'b0;
        chk("s5_active_after_stop", 32'(stream_active), 32'd0);
        wait_done("s5");
        tick(10);
        chk("s5_reads_issued", 32'(n_rd_issued - ib), 32'd1);
        chk("s5_reads_done",   32'(n_rd_done - db),   32'd1);
        chk("s5_no_push",      32'(q_pop.size() - pb), 32'd0);
        chk("s5_rd_valid",     32'(rd_valid),         32'd0);
        chk("s5_active",       32'(stream_active),    32'd0);

        // Start strobe held until busy, across both controller phases
        chk("start_hold_violations", 32'(viol),           32'd0);
        chk("start_hold_min_ge2",    32'(min_len >= 2),   32'd1);
        chk("start_hold_max_ge3",    32'(max_len >= 3),   32'd1);

        // Asynchronous reset in the middle of a read request
        pulse_start(16'h0500, 16'd2);
        n = 0;
        while (!ctrl_start_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s6_start_seen", 32'(ctrl_start_read), 32'd1);
        chk("s6_addr_before", 32'(ctrl_addr),      32'h00000500);
        #2;
        rstn = 1'b0;
        #1;
        chk("s6_start_read", 32'(ctrl_start_read), 32'd0);
        chk("s6_ctrl_addr",  32'(ctrl_addr),       32'd0);
        chk("s6_active",     32'(stream_active),   32'd0);
        chk("s6_wr_ready",   32'(wr_ready),        32'd1);
        chk("s6_rd_valid",   32'(rd_valid),        32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick(20);
        chk("s6_idle_after_reset", 32'(stream_active),   32'd0);
        chk("s6_no_restart",       32'(ctrl_start_read), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_read_streamer.md
# spi_ram_read_streamer

Request sequencer sitting directly upstream of the SPI RAM controller; it is the only agent driving the controller's start/addr/data inputs. It streams sequential words from a base address into a small FIFO for a consumer (e.g. video/line fetch) and interleaves single-word write requests, giving writes priority. It also converts the controller's start semantics into clean valid/ready handshakes: start held until busy is seen, result captured when busy falls.

## Interface
- DATA_WIDTH_BYTES, 4: word size; must match the controller.
- ADDR_BITS, 16: byte address width; must match the controller.
- FIFO_DEPTH, 4: read FIFO entries; power of 2, ≥2.
- clk  in  1  system clock, same clock as the controller.
- rstn  in  1  reset, asynchronous, active-low; also routed to the controller.
- stream_start  in  1  pulse; latch base/len, flush FIFO, begin streaming.
- stream_stop  in  1  pulse; cancel remaining reads, flush FIFO.
- stream_base  in  ADDR_BITS  first byte address.
- stream_len  in  ADDR_BITS  word count; 0 = no reads.
- stream_active  out  1  high while reads remain or one is in flight.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  DATA_WIDTH_BYTES*8  FIFO head word, big-endian as from the controller.
- rd_ready  in  1  pop when rd_valid & rd_ready.
- wr_valid  in  1  write request; wr_addr/wr_data stable while high.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_addr  in  ADDR_BITS; wr_data  in  DATA_WIDTH_BYTES*8.
- ctrl_addr  out  ADDR_BITS; ctrl_data  out  DATA_WIDTH_BYTES*8; ctrl_start_read  out  1; ctrl_start_write  out  1.
- ctrl_data_out  in  DATA_WIDTH_BYTES*8; ctrl_busy  in  1.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT.
- IDLE: wr_valid → latch wr_addr/wr_data into ctrl_addr/ctrl_data, go WR_ISSUE (wr_ready = 1 only in IDLE). Else if remaining≠0 and FIFO count < FIFO_DEPTH → ctrl_addr ← next_addr, go RD_ISSUE.
- RD_ISSUE/WR_ISSUE: hold corresponding ctrl_start_* high until ctrl_busy=1, then deassert and go RD_WAIT/WR_WAIT. Start is never dropped before busy is seen; the controller samples start only on alternate cycles.
- RD_WAIT: on ctrl_busy=0, push ctrl_data_out unless discard flag set; next_addr += DATA_WIDTH_BYTES, modulo 2^ADDR_BITS; remaining −= 1; → IDLE.
- WR_WAIT: on ctrl_busy=0 → IDLE.
- stream_start: next_addr ← stream_base, remaining ← stream_len, FIFO flushed. If a read is in RD_ISSUE/RD_WAIT, set discard; that transaction completes normally, its data is dropped, and remaining/next_addr are not updated by it.
- stream_stop: remaining ← 0, FIFO flush, discard as above. stream_start wins if both are asserted.
- Writes in flight are never cancelled. No coherency: a write to an address already in the FIFO does not update it.
- stream_active = (remaining≠0) | (state∈{RD_ISSUE,RD_WAIT} & !discard).

## Timing
- Reset values: state IDLE, ctrl_start_read/write 0, ctrl_addr 0, ctrl_data 0, FIFO empty (rd_valid 0, rd_data 0), remaining 0, stream_active 0, discard 0; wr_ready follows state (1).
- rd_valid rises the cycle after the RD_WAIT cycle that sees ctrl_busy=0; no bypass of an empty FIFO.
- Push and pop in the same cycle: count unchanged. Push never occurs at full because a read is only issued with count < FIFO_DEPTH.
- wr_valid and a pending read in the same IDLE cycle: write is issued.
- Next operation is issued at the earliest on the cycle after returning to IDLE.
- Reset mid-transaction: asynchronous return to reset values; the controller is reset by the same rstn.

## Structure
- Package spi_ram_pkg: FSM state constants, DATA_WIDTH_BITS derivation. Shared with the controller's users.
- Sub-module spi_ram_word_fifo: synchronous FIFO with push, pop, flush, count, and registered head.

## Test plan
Use a behavioural controller model: memory byte at address A = A[7:0]; start sampled only on alternate cycles; busy latency realistic.
- base 0x0100, len 3, rd_ready=1 → rd_data 0x00010203, 0x04050607, 0x08090A0B; stream_active then falls; no 4th read.
- base 0xFFFC, len 2 → 0xFCFDFEFF then 0x00010203 (address wrap).
- len 8, rd_ready=0 → exactly 4 reads issued, then stall with rd_valid=1. Releasing rd_ready drains all 8 words in order.
- wr_valid with addr 0x0040, data 0xDEADBEEF, asserted during streaming → write issued after the current read, before the next read; wr_ready high for exactly one cycle.
- stream_stop during RD_WAIT → that read completes on the bus, nothing is pushed, rd_valid 0, stream_active 0.
- Start pulsed on a controller non-sampling cycle → ctrl_start held ≥2 cycles until busy=1. Async rstn low mid-read → all outputs return to reset values immediately.
